// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, byte + ready flag.
// Optional stop-bit error flag frm_err is built when UART_RX_FRAME_ERR_EN is defined.
module uart_rx #(
    parameter int BAUD_DIV = 2605,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frm_err
`endif
);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_sync;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shft;
    logic        start, shift, false_start, done;

    // RX is asynchronous; both stages reset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_sync) state_nxt = RECEIVE;
            RECEIVE: if (false_start || done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start       = (state == IDLE) && !rx_sync;
        shift       = (state == RECEIVE) && (baud_cnt == 12'd0);
        false_start = shift && (bit_cnt == 4'd0) && rx_sync;
        done        = shift && (bit_cnt == 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= 12'd0;
            bit_cnt  <= 4'd0;
            shft     <= 9'h000;
        end else if (start) begin
            baud_cnt <= 12'(HALF_DIV);
            bit_cnt  <= 4'd0;
        end else if (shift) begin
            baud_cnt <= 12'(BAUD_DIV - 1);
            // A start bit that reads high at mid-bit was noise; leave the last byte intact.
            if (!false_start) begin
                shft    <= {rx_sync, shft[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else if (state == RECEIVE) begin
            baud_cnt <= baud_cnt - 12'd1;
        end
    end

    // Setting on the stop sample wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 rdy <= 1'b0;
        else if (done)              rdy <= 1'b1;
        else if (start || clr_rdy)  rdy <= 1'b0;
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 frm_err <= 1'b0;
        else if (done)              frm_err <= !rx_sync;
        else if (start || clr_rdy)  frm_err <= 1'b0;
    end
`endif

    assign rx_data = shft[7:0];

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced baud divisor; frames are bit-banged on RX.
module tb_uart_rx;
    localparam int B = 16;
    localparam int H = B / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frm_err;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    logic rdy_q = 1'b0;

    uart_rx #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy)
`ifdef UART_RX_FRAME_ERR_EN
        , .frm_err(frm_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy === 1'b1 && rdy_q !== 1'b1) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        rdy_q = rdy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        tick(B);
    endtask

    task automatic send_frame(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
`ifdef UART_RX_FRAME_ERR_EN
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
`endif
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_frame();
        int c0, st, lat;
        c0 = rise_cnt;
        st = cyc;
        send_frame(8'hA5);
        tick(2);
        lat = rise_cyc - st;
        checks++; if (rise_cnt !== c0 + 1) begin errors++; $display("FAIL frame_rises: got %0d want %0d", rise_cnt - c0, 1); end
        checks++; if (lat < H + 9*B + 2 || lat > H + 9*B + 4) begin errors++; $display("FAIL frame_latency: got %0d want %0d +-1", lat, H + 9*B + 3); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL frame_data: got %h want a5", rx_data); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL frame_rdy: got %b want 1", rdy); end
`ifdef UART_RX_FRAME_ERR_EN
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL frame_frm_err: got %b want 0", frm_err); end
`endif
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL clr_rdy: got %b want 0", rdy); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL clr_data_stable: got %h want a5", rx_data); end
        tick(2);
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = rise_cnt;
        send_frame(8'h00);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy1: got %b want 1", rdy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL b2b_data1: got %h want 00", rx_data); end
        drive_bit(1'b0);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_drop: got %b want 0", rdy); end
        for (int i = 0; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        tick(2);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy2: got %b want 1", rdy); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_data2: got %h want ff", rx_data); end
        checks++; if (rise_cnt !== c0 + 2) begin errors++; $display("FAIL b2b_rises: got %0d want 2", rise_cnt - c0); end
    endtask

    task automatic test_clr_collision();
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL coll_pre_clr: got %b want 0", rdy); end
        fork
            send_frame(8'h96);
            begin
                tick(H + 9*B + 3);
                clr_rdy = 1'b1;
                tick(1);
                clr_rdy = 1'b0;
            end
        join
        tick(2);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL coll_rdy: got %b want 1", rdy); end
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL coll_data: got %h want 96", rx_data); end
    endtask

    task automatic test_glitch();
        int c0;
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        c0 = rise_cnt;
        RX = 1'b0;
        tick(4);
        RX = 1'b1;
        tick(3 * B);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b want 0", rdy); end
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL glitch_data: got %h want 96", rx_data); end
        checks++; if (rise_cnt !== c0) begin errors++; $display("FAIL glitch_rises: got %0d want 0", rise_cnt - c0); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h7E);
        tick(2);
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(i[0]);
        rst_n = 1'b0;
        #1;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy: got %b want 0", rdy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        tick(2);
        RX = 1'b1;
        rst_n = 1'b1;
        tick(B);
        send_frame(8'h3C);
        tick(2);
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rstmid_next_data: got %h want 3c", rx_data); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rstmid_next_rdy: got %b want 1", rdy); end
    endtask

    // Stop bit held low only past its sample point so the line is idle before IDLE looks again.
    task automatic test_stop_low();
        logic [7:0] d;
        d = 8'h5A;
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        RX = 1'b0;
        tick(H + 2);
        RX = 1'b1;
        tick(4);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL stoplow_rdy: got %b want 1", rdy); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL stoplow_data: got %h want 5a", rx_data); end
`ifdef UART_RX_FRAME_ERR_EN
        checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL stoplow_frm_err: got %b want 1", frm_err); end
`endif
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL stoplow_clr_rdy: got %b want 0", rdy); end
`ifdef UART_RX_FRAME_ERR_EN
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL stoplow_clr_frm_err: got %b want 0", frm_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_clr_collision();
        test_glitch();
        test_reset_mid();
        test_stop_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
